// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    HALTED    = 2'd2
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  localparam int LAT_CNT_W   = 3;
  localparam int DEFER_CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side request/response and memory-macro signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              halted;

  // master: the arbiter itself; slave: pipeline stages plus memory macro
  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy, halted
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy, halted
  );

endinterface

// File: rtl/mem_port_arbiter_sel.sv
// LS-priority pick with anti-starvation override for a waiting IF request.
module arb_priority_sel
  import mem_arb_pkg::*;
#(
  parameter int MAX_DEFER = 2
) (
  input  logic                   if_req,
  input  logic                   ls_req,
  input  logic [DEFER_CNT_W-1:0] defer_cnt,
  output logic                   valid,
  output logic                   winner
);

  localparam logic [DEFER_CNT_W-1:0] DEFER_LIMIT = DEFER_CNT_W'(MAX_DEFER);

  logic if_starved;

  assign if_starved = (defer_cnt >= DEFER_LIMIT);
  assign valid      = if_req | ls_req;
  assign winner     = (if_req && (if_starved || !ls_req)) ? REQ_IF : REQ_LS;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF and LS with fixed read latency and halt drain.
//
// state     | meaning
// IDLE      | no read in flight, may grant
// READ_WAIT | read in flight, counting down the memory latency
// HALTED    | stopped by haltext, requests ignored
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 2,
  parameter int MAX_DEFER = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               haltext,
  mem_port_arbiter_if.master bus
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_t             state, state_nx;
  logic [LAT_CNT_W-1:0]   lat_cnt, lat_cnt_nx;
  logic [DEFER_CNT_W-1:0] defer_cnt, defer_nx;
  logic                   rd_owner, rd_owner_nx;

  logic              if_gnt_q, ls_gnt_q, mem_en_q, mem_we_q;
  logic              if_rvalid_q, ls_rvalid_q, busy_q, halted_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nx;
  logic              if_gnt_nx, ls_gnt_nx, mem_we_nx;
  logic              if_rvalid_nx, ls_rvalid_nx;

  logic sel_valid, sel_winner;
  logic read_done, can_grant, grant;

  arb_priority_sel #(.MAX_DEFER(MAX_DEFER)) u_sel (
    .if_req    (bus.if_req),
    .ls_req    (bus.ls_req),
    .defer_cnt (defer_cnt),
    .valid     (sel_valid),
    .winner    (sel_winner)
  );

  always_comb begin
    state_nx     = state;
    lat_cnt_nx   = lat_cnt;
    defer_nx     = defer_cnt;
    rd_owner_nx  = rd_owner;
    mem_addr_nx  = mem_addr_q;
    mem_wdata_nx = mem_wdata_q;
    if_gnt_nx    = 1'b0;
    ls_gnt_nx    = 1'b0;
    mem_we_nx    = 1'b0;
    if_rvalid_nx = 1'b0;
    ls_rvalid_nx = 1'b0;
    grant        = 1'b0;

    read_done = (state == READ_WAIT) && (lat_cnt == '0);

    case (state)
      IDLE: begin
        if (haltext) state_nx = HALTED;
      end
      READ_WAIT: begin
        if (read_done) begin
          state_nx = IDLE;
          if (rd_owner == REQ_LS) ls_rvalid_nx = 1'b1;
          else                    if_rvalid_nx = 1'b1;
        end else begin
          lat_cnt_nx = lat_cnt - LAT_CNT_W'(1);
        end
      end
      HALTED: begin
        if (!haltext) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // A completing read frees the port in the same cycle its rvalid goes out.
    can_grant = !haltext && ((state == IDLE) || read_done);

    if (can_grant && sel_valid) begin
      grant = 1'b1;
      if (sel_winner == REQ_LS) begin
        ls_gnt_nx    = 1'b1;
        mem_we_nx    = bus.ls_we;
        mem_addr_nx  = bus.ls_addr;
        mem_wdata_nx = bus.ls_wdata;
        if (!bus.ls_we) begin
          state_nx    = READ_WAIT;
          lat_cnt_nx  = LAT_LOAD;
          rd_owner_nx = REQ_LS;
        end
      end else begin
        if_gnt_nx    = 1'b1;
        mem_addr_nx  = bus.if_addr;
        mem_wdata_nx = '0;
        state_nx     = READ_WAIT;
        lat_cnt_nx   = LAT_LOAD;
        rd_owner_nx  = REQ_IF;
      end
    end

    // Starvation count is frozen while halted so it survives the stop.
    if (state != HALTED) begin
      if ((grant && (sel_winner == REQ_IF)) || !bus.if_req) defer_nx = '0;
      else if (grant)                                        defer_nx = defer_cnt + DEFER_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      defer_cnt   <= '0;
      rd_owner    <= REQ_IF;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state       <= state_nx;
      lat_cnt     <= lat_cnt_nx;
      defer_cnt   <= defer_nx;
      rd_owner    <= rd_owner_nx;
      if_gnt_q    <= if_gnt_nx;
      ls_gnt_q    <= ls_gnt_nx;
      mem_en_q    <= grant;
      mem_we_q    <= mem_we_nx;
      mem_addr_q  <= mem_addr_nx;
      mem_wdata_q <= mem_wdata_nx;
      if_rvalid_q <= if_rvalid_nx;
      ls_rvalid_q <= ls_rvalid_nx;
      busy_q      <= (state_nx == READ_WAIT);
      halted_q    <= (state_nx == HALTED);
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halted_q;
  assign bus.if_rdata  = if_rvalid_q ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = ls_rvalid_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed test-plan steps followed by random traffic, checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_LAT   = 2;
  localparam int MAX_DEFER = 2;

  logic clk = 1'b0;
  logic reset;
  logic haltext;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .MAX_DEFER(MAX_DEFER)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .haltext (haltext),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] mem_arr [16];

  typedef struct {int cycle; logic is_ls; logic [31:0] data;} rv_t;
  typedef struct {int cycle; logic [31:0] data;} md_t;
  rv_t rv_q[$];
  md_t md_q[$];

  // reference model: read completion cycle, halt flag, starvation count
  int m_rv_at, m_last_rv, m_defer;
  bit m_halted;

  logic        e_if_gnt, e_ls_gnt, e_en, e_we, e_busy, e_halted, e_if_rv, e_ls_rv;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_ls_rdata;

  task automatic chk1(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Predict what the arbiter shows in the cycle after the coming posedge.
  task automatic predict();
    int t;
    bit was_halted, if_win, ls_win;
    t = cyc + 1;
    {e_if_gnt, e_ls_gnt, e_en, e_we, e_busy, e_halted, e_if_rv, e_ls_rv} = '0;
    e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_ls_rdata = '0;
    if_win = 1'b0; ls_win = 1'b0;
    if (reset) begin
      m_rv_at = 0; m_last_rv = -1; m_defer = 0; m_halted = 1'b0;
      rv_q.delete();
      return;
    end
    if (rv_q.size() > 0 && rv_q[0].cycle == t) begin
      if (rv_q[0].is_ls) begin e_ls_rv = 1'b1; e_ls_rdata = rv_q[0].data; end
      else               begin e_if_rv = 1'b1; e_if_rdata = rv_q[0].data; end
      void'(rv_q.pop_front());
      m_last_rv = t;
    end
    was_halted = m_halted;
    if (m_halted) begin
      if (!haltext) m_halted = 1'b0;
    end else if (t >= m_rv_at) begin
      if (haltext) begin
        if (m_last_rv != t) m_halted = 1'b1;
      end else if (bus.if_req || bus.ls_req) begin
        if_win = bus.if_req && (!bus.ls_req || m_defer >= MAX_DEFER);
        ls_win = !if_win;
      end
    end
    if (if_win) begin
      e_if_gnt = 1'b1; e_en = 1'b1; e_addr = bus.if_addr;
      m_rv_at = t + MEM_LAT;
      rv_q.push_back('{cycle: t + MEM_LAT, is_ls: 1'b0, data: mem_arr[bus.if_addr[5:2]]});
    end
    if (ls_win) begin
      e_ls_gnt = 1'b1; e_en = 1'b1; e_we = bus.ls_we; e_addr = bus.ls_addr;
      if (bus.ls_we) e_wdata = bus.ls_wdata;
      else begin
        m_rv_at = t + MEM_LAT;
        rv_q.push_back('{cycle: t + MEM_LAT, is_ls: 1'b1, data: mem_arr[bus.ls_addr[5:2]]});
      end
    end
    if (!was_halted) begin
      if (if_win || !bus.if_req) m_defer = 0;
      else if (ls_win)           m_defer++;
    end
    e_busy   = (t < m_rv_at);
    e_halted = m_halted;
  endtask

  task automatic check_cycle();
    chk1("if_gnt", bus.if_gnt, e_if_gnt);
    chk1("ls_gnt", bus.ls_gnt, e_ls_gnt);
    chk1("mem_en", bus.mem_en, e_en);
    chk1("mem_we", bus.mem_we, e_we);
    chk1("busy", bus.busy, e_busy);
    chk1("halted", bus.halted, e_halted);
    chk1("if_rvalid", bus.if_rvalid, e_if_rv);
    chk1("ls_rvalid", bus.ls_rvalid, e_ls_rv);
    chk32("if_rdata", bus.if_rdata, e_if_rdata);
    chk32("ls_rdata", bus.ls_rdata, e_ls_rdata);
    if (e_en) chk32("mem_addr", bus.mem_addr, e_addr);
    if (e_en && e_we) chk32("mem_wdata", bus.mem_wdata, e_wdata);
  endtask

  // Memory macro: stores writes, returns read data MEM_LAT cycles after mem_en.
  task automatic macro_capture();
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1)
      mem_arr[bus.mem_addr[5:2]] = bus.mem_wdata;
    else if (bus.mem_en === 1'b1)
      md_q.push_back('{cycle: cyc + MEM_LAT, data: mem_arr[bus.mem_addr[5:2]]});
  endtask

  task automatic step();
    predict();
    @(posedge clk);
    cyc++;
    #1;
    while (md_q.size() > 0 && md_q[0].cycle < cyc) void'(md_q.pop_front());
    if (md_q.size() > 0 && md_q[0].cycle == cyc) bus.mem_rdata = md_q.pop_front().data;
    else                                         bus.mem_rdata = $urandom;
    @(negedge clk);
    check_cycle();
    macro_capture();
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(15, 0)) << 2;
  endfunction

  initial begin
    int t0, gcount, first_if;
    for (int i = 0; i < 16; i++) mem_arr[i] = 32'h5A00_0000 + 32'(i * 32'h0101);
    mem_arr[4] = 32'hDEAD_BEEF;
    reset = 1'b1; haltext = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.mem_rdata = '0;
    m_rv_at = 0; m_last_rv = -1; m_defer = 0; m_halted = 1'b0;

    step(); step();
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_halted", bus.halted, 1'b0);
    reset = 1'b0;
    step();

    // 1: single IF read
    t0 = cyc;
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    step();
    chk1("t1_if_gnt", bus.if_gnt, 1'b1);
    chk32("t1_mem_addr", bus.mem_addr, 32'h10);
    chk1("t1_mem_we", bus.mem_we, 1'b0);
    chk1("t1_busy_c1", bus.busy, 1'b1);
    bus.if_req = 1'b0;
    step();
    chk1("t1_busy_c2", bus.busy, 1'b1);
    step();
    chk1("t1_if_rvalid", bus.if_rvalid, 1'b1);
    chk32("t1_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
    chk1("t1_busy_c3", bus.busy, 1'b0);
    step();

    // 2: simultaneous requests, LS first
    bus.if_req = 1'b1; bus.if_addr = 32'h0C;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h20;
    step();
    chk1("t2_ls_gnt", bus.ls_gnt, 1'b1);
    chk1("t2_if_wait", bus.if_gnt, 1'b0);
    bus.ls_req = 1'b0;
    step(); step();
    chk1("t2_ls_rvalid", bus.ls_rvalid, 1'b1);
    chk32("t2_ls_rdata", bus.ls_rdata, 32'h5A00_0808);
    chk1("t2_if_gnt", bus.if_gnt, 1'b1);
    bus.if_req = 1'b0;
    step(); step();
    chk1("t2_if_rvalid", bus.if_rvalid, 1'b1);
    step();

    // 3: starvation guard under a held write stream
    t0 = cyc; gcount = 0; first_if = -1;
    bus.if_req = 1'b1; bus.if_addr = 32'h18;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h30; bus.ls_wdata = $urandom;
    for (int k = 0; k < 11; k++) begin
      step();
      if (bus.ls_gnt === 1'b1 || bus.if_gnt === 1'b1) begin
        chk1("t3_if_turn", bus.if_gnt, (gcount % 3) == 2);
        if (bus.if_gnt === 1'b1 && first_if < 0) first_if = cyc - t0;
        gcount++;
        if (bus.ls_gnt === 1'b1) bus.ls_wdata = $urandom;
      end
    end
    chk32("t3_grants", 32'(gcount), 32'd9);
    chk32("t3_first_if_cycle", 32'(first_if), 32'd3);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    step(); step(); step();

    // 4: halt while a read is in flight
    bus.if_req = 1'b1; bus.if_addr = 32'h08;
    step();
    chk1("t4_if_gnt", bus.if_gnt, 1'b1);
    haltext = 1'b1; bus.if_req = 1'b0;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h34; bus.ls_wdata = 32'hCAFE_0001;
    step(); step();
    chk1("t4_if_rvalid", bus.if_rvalid, 1'b1);
    chk1("t4_not_halted_c3", bus.halted, 1'b0);
    step();
    chk1("t4_halted_c4", bus.halted, 1'b1);
    step(); step();
    chk1("t4_no_gnt_halted", bus.ls_gnt, 1'b0);
    haltext = 1'b0;
    step();
    chk1("t4_halted_falls", bus.halted, 1'b0);
    chk1("t4_no_gnt_yet", bus.ls_gnt, 1'b0);
    step();
    chk1("t4_ls_gnt_resume", bus.ls_gnt, 1'b1);
    bus.ls_req = 1'b0;
    step();

    // 5: reset aborts an LS read
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h24;
    step();
    chk1("t5_ls_gnt", bus.ls_gnt, 1'b1);
    bus.ls_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h2C;
    step();
    reset = 1'b1;
    step();
    chk1("t5_no_ls_rvalid", bus.ls_rvalid, 1'b0);
    chk1("t5_busy_clear", bus.busy, 1'b0);
    chk32("t5_ls_rdata_zero", bus.ls_rdata, 32'h0);
    reset = 1'b0;
    step();
    chk1("t5_if_gnt_after_rst", bus.if_gnt, 1'b1);
    bus.if_req = 1'b0;
    step(); step(); step();

    // 6: back-to-back LS writes
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h40; bus.ls_wdata = 32'h1111_2222;
    step();
    chk1("t6_gnt_a", bus.ls_gnt, 1'b1);
    chk1("t6_we_a", bus.mem_we, 1'b1);
    chk32("t6_wdata_a", bus.mem_wdata, 32'h1111_2222);
    bus.ls_addr = 32'h44; bus.ls_wdata = 32'h3333_4444;
    step();
    chk1("t6_gnt_b", bus.ls_gnt, 1'b1);
    chk32("t6_addr_b", bus.mem_addr, 32'h44);
    chk32("t6_wdata_b", bus.mem_wdata, 32'h3333_4444);
    chk1("t6_busy", bus.busy, 1'b0);
    bus.ls_req = 1'b0;
    step();
    chk1("t6_en_off", bus.mem_en, 1'b0);
    step();

    // random traffic; requesters hold req until their grant
    for (int i = 0; i < 4000; i++) begin
      step();
      if (bus.if_req && e_if_gnt) begin
        bus.if_req = ($urandom_range(1, 0) == 1); bus.if_addr = rand_addr();
      end else if (!bus.if_req && $urandom_range(2, 0) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = rand_addr();
      end
      if (bus.ls_req && e_ls_gnt) begin
        bus.ls_req = ($urandom_range(1, 0) == 1);
        bus.ls_we = $urandom_range(1, 0) == 1; bus.ls_addr = rand_addr(); bus.ls_wdata = $urandom;
      end else if (!bus.ls_req && $urandom_range(2, 0) == 0) begin
        bus.ls_req = 1'b1;
        bus.ls_we = $urandom_range(1, 0) == 1; bus.ls_addr = rand_addr(); bus.ls_wdata = $urandom;
      end
      if (haltext) haltext = ($urandom_range(3, 0) != 0);
      else         haltext = ($urandom_range(39, 0) == 0);
      reset = ($urandom_range(199, 0) == 0);
    end

    reset = 1'b0; haltext = 1'b0; bus.if_req = 1'b0; bus.ls_req = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the CPU fetch stage (IF) and the load/store stage (LS).
- Sequences each access over the fixed memory read latency.
- Implements the external halt (haltext) drain-and-stop behaviour.
- Sits between the CPU pipeline and the memory macro; the testbench drives clk/reset/haltext exactly as for the CPU top.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory read latency in cycles (legal 1..4)
MAX_DEFER, 2, max consecutive LS grants while IF is waiting (legal 1..7)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
haltext  in  1  external halt request (level)
if_req  in  1  IF read request (level, held until if_gnt)
if_addr  in  ADDR_W  IF address
if_gnt  out  1  IF request accepted (1-cycle pulse)
if_rvalid  out  1  IF read data valid (1-cycle pulse)
if_rdata  out  DATA_W  IF read data
ls_req  in  1  LS request (level, held until ls_gnt)
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_W  LS address
ls_wdata  in  DATA_W  LS write data
ls_gnt  out  1  LS request accepted (1-cycle pulse)
ls_rvalid  out  1  LS read data valid (1-cycle pulse)
ls_rdata  out  DATA_W  LS read data
mem_en  out  1  memory command strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  access in flight
halted  out  1  arbiter stopped by haltext

Behaviour:
Cycle numbering:
- "Cycle t" is the interval following posedge t.
- All outputs except if_rdata and ls_rdata are registered.

Reset:
- All outputs are 0 and state is IDLE.
- defer_cnt = 0; the latency counter is 0.
- Reset mid-access aborts it: no rvalid is issued for the aborted read.

States:
- IDLE: may grant.
- READ_WAIT: read in flight.
- HALTED: stopped.

Grant:
- Conditions at posedge t: state IDLE, haltext = 0, and a qualifying req.
- Outputs in cycle t:
  - gnt for the winner.
  - mem_en = 1.
  - mem_we = ls_we for LS, 0 for IF.
  - mem_addr and mem_wdata driven from the winner's inputs sampled at posedge t.
- mem_en, mem_we and gnt return to 0 in cycle t+1 unless a new grant occurs.
- A requester's req sampled at the posedge ending its gnt cycle is ignored; there is no double grant.

Arbitration:
- LS has priority over IF.
- defer_cnt increments on each LS grant made while if_req = 1.
- defer_cnt clears on any IF grant and whenever if_req = 0 at a posedge.
- If defer_cnt == MAX_DEFER and if_req = 1, IF wins regardless of ls_req.

Writes:
- No rvalid is issued.
- State stays IDLE, so the next grant can occur in cycle t+1.

Reads:
- state becomes READ_WAIT; busy = 1 in cycles t..t+MEM_LAT-1.
- The requester's rvalid = 1 in cycle t+MEM_LAT.
- rdata = mem_rdata combinationally in that cycle; rdata is don't-care at other times but held at 0 when rvalid = 0.
- The state returns to IDLE so that the next gnt can occur in cycle t+MEM_LAT (same cycle as rvalid).

Halt:
- haltext = 1 sampled in IDLE: no grant is made, state becomes HALTED, and halted = 1 from the following cycle.
- haltext sampled during READ_WAIT: the read completes (rvalid is still issued), then the arbiter enters HALTED.
- While HALTED, requests are ignored and req lines must stay held.
- haltext = 0 sampled in HALTED: return to IDLE; halted = 0 and grants are possible from the next posedge.
- defer_cnt is preserved across a halt.

Simultaneous events:
- reset overrides haltext, which overrides any grant.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, READ_WAIT, HALTED);
  - the requester ID constants REQ_IF = 0 and REQ_LS = 1;
  - the latency-counter width constant (3 bits).
- One sub-module, arb_priority_sel: combinational LS-priority/anti-starvation pick from (if_req, ls_req, defer_cnt, MAX_DEFER) giving a valid flag and the winner ID.

Test Plan:
1. Default parameters (MEM_LAT = 2). if_req with addr 0x10 rising before posedge 1 -> if_gnt and mem_en in cycle 1, mem_addr = 0x10, mem_we = 0, busy in cycles 1–2, if_rvalid in cycle 3 with if_rdata = mem_rdata (0xDEADBEEF).
2. if_req and ls_req (read, 0x20) both high at posedge 1 -> ls_gnt in cycle 1, ls_rvalid in cycle 3, if_gnt in cycle 3, if_rvalid in cycle 5.
3. Starvation, MAX_DEFER = 2:
   - if_req and a stream of LS writes held continuously -> grants LS, LS, IF, LS, LS, IF…
   - With back-to-back writes, if_gnt appears on the 3rd grant cycle.
4. Halt mid-read:
   - IF read granted in cycle 1, haltext = 1 from cycle 1 -> if_rvalid still in cycle 3, halted = 1 from cycle 4, no gnt while a held ls_req waits.
   - Drop haltext -> ls_gnt one cycle after halted falls.
5. Reset mid-read: reset in cycle 2 of an LS read -> cycle 3 has all outputs 0 and no ls_rvalid ever for that read; the next held request is granted normally after reset deasserts.
6. Back-to-back LS writes 0x40, 0x44 -> ls_gnt, mem_en and mem_we high in consecutive cycles, mem_wdata tracking, no rvalid, busy stays 0.
